// File: rtl/cs_decoder.sv
// cs_decoder
// Registered chip-select decoder with a per-slave ready handshake. A request
// (en1 && en2) latches adr, raises one-hot ce for that slave and holds it until
// the selected slave's rdy bit is sampled high. Optionally a timeout aborts the
// transaction after TIMEOUT cycles without ready.
//
// Build option: define CS_DECODER_TIMEOUT_EN to compile in the timeout counter
// and err path. Without it, ACTIVE is left only by rdy[sel] or reset, err is 0
// and TIMEOUT has no effect.
//
// Parameters:
//   ADR_W    address width, N = 2**ADR_W slaves (1..6)
//   TIMEOUT  max cycles ce is held without ready (>= 1)
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   en1,en2  request enables; a request exists only when both are high
//   adr      slave index, sampled when a request is accepted
//   rdy      per-slave ready; only rdy[sel] is observed while ACTIVE
//   ce       registered one-hot chip select, zero when idle
//   busy     high while a transaction is open
//   ack      one-cycle pulse: completed by slave ready
//   err      one-cycle pulse: aborted by timeout
//
// state  | meaning
// IDLE   | no transaction open; ce = 0; waiting for en1 && en2
// ACTIVE | ce[sel] held; waiting for rdy[sel] (or timeout)
module cs_decoder #(
    parameter int ADR_W   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en1,
    input  logic                  en2,
    input  logic [ADR_W-1:0]      adr,
    input  logic [(2**ADR_W)-1:0] rdy,
    output logic [(2**ADR_W)-1:0] ce,
    output logic                  busy,
    output logic                  ack,
    output logic                  err
);

    localparam int N = 2**ADR_W;

    if (ADR_W < 1 || ADR_W > 6 || TIMEOUT < 1) begin : g_param_check
        $error("cs_decoder: ADR_W must be 1..6 and TIMEOUT >= 1");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [ADR_W-1:0] sel_q;
    logic [ADR_W-1:0] sel_d;
    logic [N-1:0]     ce_d;
    logic             busy_d;
    logic             ack_d;
    logic             req;
    logic             sel_rdy;
    logic             timeout_hit;

    assign req     = en1 & en2;
    assign sel_rdy = rdy[sel_q];

`ifdef CS_DECODER_TIMEOUT_EN
    localparam int            CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          err_d;

    // count holds the number of ACTIVE edges already passed, so hitting TC on
    // an edge means ce has been high for exactly TIMEOUT cycles after it.
    assign timeout_hit = (count_q == TC);
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ce      <= '0;
            busy    <= 1'b0;
            ack     <= 1'b0;
`ifdef CS_DECODER_TIMEOUT_EN
            err     <= 1'b0;
            count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ce      <= ce_d;
            busy    <= busy_d;
            ack     <= ack_d;
`ifdef CS_DECODER_TIMEOUT_EN
            err     <= err_d;
            count_q <= count_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = ACTIVE;
            ACTIVE:  if (sel_rdy || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs; rdy has priority over timeout.
    always_comb begin
        sel_d   = sel_q;
        ce_d    = '0;
        busy_d  = 1'b0;
        ack_d   = 1'b0;
`ifdef CS_DECODER_TIMEOUT_EN
        err_d   = 1'b0;
        count_d = count_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    sel_d      = adr;
                    ce_d[adr]  = 1'b1;
                    busy_d     = 1'b1;
`ifdef CS_DECODER_TIMEOUT_EN
                    count_d    = '0;
`endif
                end
            end
            ACTIVE: begin
                if (sel_rdy) begin
                    ack_d = 1'b1;
                end else if (timeout_hit) begin
`ifdef CS_DECODER_TIMEOUT_EN
                    err_d = 1'b1;
`endif
                end else begin
                    ce_d   = ce;
                    busy_d = 1'b1;
`ifdef CS_DECODER_TIMEOUT_EN
                    count_d = count_q + CW'(1);
`endif
                end
            end
            default: begin
                ce_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_cs_decoder.sv
// Scoreboard bench for cs_decoder (ADR_W=2, TIMEOUT=4). The driver issues
// transactions with a chosen ready delay and pushes the expected outcome
// (ack or err, slave index, ce length, first ce cycle); a monitor pops and
// compares whenever ack or err pulses, and checks ce/busy invariants each cycle.
module tb_cs_decoder;

    localparam int ADR_W = 2;
    localparam int TO    = 4;
`ifdef CS_DECODER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       en1;
    logic       en2;
    logic [1:0] adr;
    logic [3:0] rdy;
    logic [3:0] ce;
    logic       busy;
    logic       ack;
    logic       err;

    cs_decoder #(.ADR_W(ADR_W), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .en1   (en1),
        .en2   (en2),
        .adr   (adr),
        .rdy   (rdy),
        .ce    (ce),
        .busy  (busy),
        .ack   (ack),
        .err   (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_err;
        int idx;
        int len;
        int start;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Monitor
    logic [3:0] prev_ce = '0;
    int         run = 0;
    int         run_idx = -1;
    int         run_start = -1;

    always @(negedge clk) begin
        exp_t e;
        chk("ce_onehot0", $onehot0(ce), 1);
        chk("busy_eq_ce_active", busy, (ce != 4'b0000));
        chk("ack_err_exclusive", (ack && err), 0);
        if (ce != 4'b0000) begin
            if (ce == prev_ce) begin
                run++;
            end else begin
                run       = 1;
                run_idx   = onehot_idx(ce);
                run_start = cyc;
            end
        end
        if (ack || err) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_completion: ack=%0b err=%0b with no open transaction (cycle %0d)", ack, err, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("done_err", err, e.is_err);
                chk("done_ack", ack, !e.is_err);
                chk("done_idx", run_idx, e.idx);
                chk("done_ce_len", run, e.len);
                chk("done_ce_start", run_start, e.start);
                chk("done_ce_low", ce, 0);
            end
        end
        if (ce == 4'b0000) run = 0;
        prev_ce = ce;
    end

    task automatic idle_drive();
        int p;
        p   = $urandom_range(0, 2);
        en1 = (p == 1);
        en2 = (p == 2);
        adr = 2'($urandom);
        rdy = 4'($urandom);
    endtask

    // Called and returning at posedge+1. d = ACTIVE edge on which rdy[a] is high.
    task automatic do_txn(input logic [1:0] a, input int d, input int gap);
        exp_t e;
        int   endj;
        en1 = 1'b1;
        en2 = 1'b1;
        adr = a;
        rdy = 4'($urandom);
        @(posedge clk);
        endj     = (TO_EN && d > TO) ? TO : d;
        e.is_err = (endj != d);
        e.idx    = a;
        e.len    = endj;
        e.start  = cyc + 1;
        exp_q.push_back(e);
        for (int j = 1; j <= endj; j++) begin
            #1;
            en1    = 1'($urandom);
            en2    = 1'($urandom);
            adr    = 2'($urandom);
            rdy    = 4'($urandom);
            rdy[a] = (j == d);
            @(posedge clk);
        end
        for (int g = 0; g < gap; g++) begin
            #1;
            idle_drive();
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        reset = 1'b1;
        en1   = 1'b1;
        en2   = 1'b1;
        adr   = 2'd2;
        rdy   = 4'b0000;

        // Reset held two edges with a request pending
        repeat (2) begin
            @(negedge clk);
            chk("rst_ce", ce, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ack", ack, 0);
            chk("rst_err", err, 0);
        end
        #1;
        reset = 1'b0;
        en1   = 1'b0;
        en2   = 1'b1;
        @(negedge clk);
        chk("post_rst_ce", ce, 0);
        chk("post_rst_busy", busy, 0);
        @(posedge clk);
        #1;

        // Enable gating only: en1=1, en2=0 for a few cycles
        for (int i = 0; i < 3; i++) begin
            en1 = 1'b1;
            en2 = 1'b0;
            adr = 2'd1;
            rdy = 4'($urandom);
            @(posedge clk);
            #1;
        end

        do_txn(2'd3, 3, 1);        // basic select
        do_txn(2'd1, 2, 0);
        do_txn(2'd0, TO, 1);       // rdy coincides with timeout edge
        do_txn(2'd0, TO + 1, 1);   // timeout (or long hold without timeout)
        do_txn(2'd2, 22, 2);       // long hold
        do_txn(2'd0, 1, 0);        // back-to-back minimum transactions
        do_txn(2'd1, 1, 0);
        do_txn(2'd1, 1, 1);

        for (int t = 0; t < 60; t++) begin
            int a;
            int d;
            int g;
            a = $urandom_range(0, 3);
            d = $urandom_range(1, TO + 3);
            g = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            do_txn(2'(a), d, g);
        end

        // Reset in the middle of a transaction, request coincident with reset
        en1 = 1'b1;
        en2 = 1'b1;
        adr = 2'd1;
        rdy = 4'b0000;
        @(posedge clk);
        #1;
        en1 = 1'b0;
        en2 = 1'b0;
        adr = 2'd2;
        rdy = 4'b1101;
        @(posedge clk);
        #1;
        reset = 1'b1;
        en1   = 1'b1;
        en2   = 1'b1;
        adr   = 2'd2;
        rdy   = 4'b0000;
        @(negedge clk);
        chk("midrst_before_ce", ce, 4'b0010);
        @(negedge clk);
        chk("midrst_ce", ce, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ack", ack, 0);
        chk("midrst_err", err, 0);
        #1;
        reset = 1'b0;
        en1   = 1'b0;
        en2   = 1'b0;
        @(negedge clk);
        chk("midrst_after_ce", ce, 0);
        chk("midrst_after_busy", busy, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cs_decoder.md
# cs_decoder

Parametrised, registered chip-select decoder with per-slave ready handshake, generalising the 2-to-4 enable/address decoder used in the UART peripheral. It accepts a request when both enables are high, latches the address, drives a one-hot chip select to one of 2**ADR_W slaves, and holds it until that slave signals ready or, optionally, a timeout expires. It sits between the bus master and the memory-mapped peripherals (UART, timers, GPIO).

## Interface
- ADR_W, default 2: address width; slave count N = 2**ADR_W; legal 1..6.
- TIMEOUT, default 16: maximum cycles a chip select is held without ready; legal >= 1; counter width $clog2(TIMEOUT+1).
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- en1  in  1  request enable A.
- en2  in  1  request enable B; a request exists only when en1 && en2.
- adr  in  ADR_W  slave index, sampled only when a request is accepted.
- rdy  in  N  per-slave ready; only bit of latched index is observed.
- ce  out  N  registered one-hot chip select (all-zero when idle).
- busy  out  1  high while a transaction is open (state ACTIVE).
- ack  out  1  one-cycle pulse: transaction completed by slave ready.
- err  out  1  one-cycle pulse: transaction aborted by timeout.

## Operation
- States: IDLE, ACTIVE. All outputs registered.
- IDLE: if en1 && en2 at an edge: latch adr into sel, ce <= one-hot(sel), busy <= 1, count <= 0, go ACTIVE. Otherwise ce = 0.
- ACTIVE: en1/en2/adr ignored; sel frozen. Each edge:
  - rdy[sel] = 1: ce <= 0, busy <= 0, ack <= 1, go IDLE.
  - else if timeout enabled and count == TIMEOUT-1: ce <= 0, busy <= 0, err <= 1, go IDLE.
  - else count <= count + 1, ce held.
- ack and err high for exactly one cycle, never simultaneously; rdy wins over timeout when both fall on the same edge.
- rdy bits other than rdy[sel] have no effect; rdy while IDLE has no effect.
- Only one ce bit ever high; ce never changes index mid-transaction.
- Reset (any state, including mid-transaction): at the next edge state = IDLE, ce = 0, busy = 0, ack = 0, err = 0, count = 0, sel = 0; a request coincident with reset is dropped.

## Timing
- Request sampled at edge k -> ce[sel] and busy high after edge k.
- rdy[sel] sampled high at edge m (m > k) -> ce/busy low and ack high after edge m; ack low after edge m+1.
- Minimum transaction: ce high 1 cycle (rdy already high at edge k+1).
- Timeout: ce high exactly TIMEOUT cycles; err after edge k+TIMEOUT.
- Back-to-back: during the ack/err cycle the block is IDLE; a request sampled at that edge reopens at once, so ce is low for exactly one cycle between transactions; peak rate one transaction per 2 cycles.

## Configuration
- CS_DECODER_TIMEOUT_EN defined: timeout counter and err path compiled in as above.
- Not defined: no counter; ACTIVE is left only by rdy[sel] or reset; err tied to 0; TIMEOUT ignored.

## Test plan
- Reset: assert reset 2 cycles with en1=en2=1, adr=2 -> ce=4'b0000, busy=ack=err=0 throughout and one cycle after release until next sampled request.
- Basic select (ADR_W=2): en1=en2=1, adr=3 at edge 0; rdy=4'b1000 at edge 3 -> ce=4'b1000 after edges 0..2, ack=1 after edge 3 only, ce=0.
- Enable gating and address freeze: en1=1,en2=0,adr=1 -> ce stays 0; then request adr=1, change adr to 2 and pulse rdy=4'b0100 while ACTIVE -> ce stays 4'b0010, no ack until rdy[1].
- Timeout (TIMEOUT=4, macro defined): request adr=0, rdy=0 -> ce=4'b0001 for exactly 4 cycles, err pulse 1 cycle, ack=0; without macro ce stays high 20+ cycles.
- Rdy/timeout tie (TIMEOUT=4): rdy[sel] first high on the 4th ACTIVE edge -> ack=1, err=0.
- Back-to-back and mid-op reset: hold en1=en2=1 with adr 0 then 1, rdy all ones -> ce 0001,0000,0010 pattern, ack every 2nd cycle; assert reset while ce=0010 -> ce=0, busy=0 next cycle, no ack/err.
